// File: rtl/loot_grab_ctrl.sv
// loot_grab_ctrl
// --------------
// Owns the grabbed-loot state at the far end of the claw motion interface.
// It consumes claw collision and return events. It drives the claw mover's
// speed: the base speed while the claw is empty, and a weight-scaled speed
// while it carries loot. When the claw returns with loot, it pulses a score
// award and an object-removal request, and it accumulates the level score.
//
// Optional feature macro: STRENGTH_POTION_EN
//   Adds the potion_active input and a frame-based potion timer. While the
//   timer is running, the carry speed chosen at grab time is doubled, capped at 8.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   startOfFrame        frame pulse (potion timer only)
//   start_level         pulse that clears all level state
//   claw_collision      claw overlaps a loot object; qualifies the three fields below
//   collision_loot_id   id of the hit loot
//   loot_weight         0=light .. 3=very heavy
//   loot_value          points for the hit loot
//   claw_returned       claw reached its origin (rising edge is the event)
//   potion_active       (STRENGTH_POTION_EN only) potion trigger, rising edge loads timer
//   move_speed          speed to the claw mover
//   carrying            claw holds loot
//   carried_id          id of the held loot
//   loot_remove         pulse: remove carried_id from the field
//   score_add           pulse: award delivered
//   score_value         award points, valid with score_add
//   level_score         saturating level score
//   miss_count          saturating count of empty returns
module loot_grab_ctrl #(
  parameter logic [3:0]  BASE_SPEED = 4'd4,
  parameter logic [15:0] SCORE_MAX  = 16'd9999,
  parameter int          NUM_LOOT   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        start_level,
  input  logic        claw_collision,
  input  logic [3:0]  collision_loot_id,
  input  logic [1:0]  loot_weight,
  input  logic [7:0]  loot_value,
  input  logic        claw_returned,
`ifdef STRENGTH_POTION_EN
  input  logic        potion_active,
`endif
  output logic [3:0]  move_speed,
  output logic        carrying,
  output logic [3:0]  carried_id,
  output logic        loot_remove,
  output logic        score_add,
  output logic [7:0]  score_value,
  output logic [15:0] level_score,
  output logic [7:0]  miss_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRAB    = 2'd1,
    CARRY   = 2'd2,
    DELIVER = 2'd3
  } state_t;

  // Powers of two keep the claw mover's line-length rescale exact.
  function automatic logic [3:0] weight_speed(input logic [1:0] w);
    logic [3:0] s;
    case (w)
      2'd0:    s = 4'd8;
      2'd1:    s = 4'd4;
      2'd2:    s = 4'd2;
      2'd3:    s = 4'd1;
      default: s = 4'd4;
    endcase
    return s;
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  move_speed_q, move_speed_d;
  logic        carrying_q, carrying_d;
  logic [3:0]  carried_id_q, carried_id_d;
  logic [1:0]  weight_q, weight_d;
  logic [7:0]  value_q, value_d;
  logic        loot_remove_q, loot_remove_d;
  logic        score_add_q, score_add_d;
  logic [7:0]  score_value_q, score_value_d;
  logic [15:0] level_score_q, level_score_d;
  logic [7:0]  miss_count_q, miss_count_d;
  logic        ret_q;
  logic        ret_rise_s;
  logic        id_ok_s;
  logic [16:0] score_sum_s;
  logic [3:0]  grab_speed_s;

  // A held claw_returned counts as a single event.
  assign ret_rise_s  = claw_returned & ~ret_q;
  assign id_ok_s     = ({28'd0, collision_loot_id} < NUM_LOOT);
  assign score_sum_s = {1'b0, level_score_q} + {9'd0, value_q};

`ifdef STRENGTH_POTION_EN
  logic       potion_q;
  logic [7:0] potion_frames_q, potion_frames_d;
  logic [3:0] base_carry_s;

  assign base_carry_s = weight_speed(weight_q);
  // The doubled speed is capped at 8, which is also the light-loot speed.
  assign grab_speed_s = (potion_frames_q == 8'd0) ? base_carry_s :
                        (base_carry_s >= 4'd4)    ? 4'd8 : {base_carry_s[2:0], 1'b0};

  // Potion timer: a rising edge reloads it, and it counts frames down to zero.
  always_comb begin
    potion_frames_d = potion_frames_q;
    if (potion_active && !potion_q) begin
      potion_frames_d = 8'd240;
    end else if (startOfFrame && (potion_frames_q != 8'd0)) begin
      potion_frames_d = potion_frames_q - 8'd1;
    end else begin
      potion_frames_d = potion_frames_q;
    end
  end

  // Potion edge-detect and timer registers.
  always_ff @(posedge clk) begin
    if (reset || start_level) begin
      potion_q        <= 1'b0;
      potion_frames_q <= 8'd0;
    end else begin
      potion_q        <= potion_active;
      potion_frames_q <= potion_frames_d;
    end
  end
`else
  logic unused_sof;
  assign unused_sof   = startOfFrame;
  assign grab_speed_s = weight_speed(weight_q);
`endif

  // Next-state and output logic for the grab/carry/deliver sequence.
  always_comb begin
    state_d       = state_q;
    move_speed_d  = move_speed_q;
    carrying_d    = carrying_q;
    carried_id_d  = carried_id_q;
    weight_d      = weight_q;
    value_d       = value_q;
    loot_remove_d = 1'b0;
    score_add_d   = 1'b0;
    score_value_d = score_value_q;
    level_score_d = level_score_q;
    miss_count_d  = miss_count_q;
    case (state_q)
      IDLE: begin
        // A collision takes precedence over a simultaneous return, so no miss is counted.
        if (claw_collision && id_ok_s) begin
          carried_id_d = collision_loot_id;
          weight_d     = loot_weight;
          value_d      = loot_value;
          state_d      = GRAB;
        end else if (ret_rise_s) begin
          miss_count_d = (miss_count_q == 8'd255) ? 8'd255 : miss_count_q + 8'd1;
          state_d      = IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      GRAB: begin
        // The speed changes one cycle after the latch. The mover has
        // already sampled the old speed on the collision cycle.
        carrying_d   = 1'b1;
        move_speed_d = grab_speed_s;
        state_d      = CARRY;
      end
      CARRY: begin
        if (ret_rise_s) begin
          state_d = DELIVER;
        end else begin
          state_d = CARRY;
        end
      end
      DELIVER: begin
        score_add_d   = 1'b1;
        loot_remove_d = 1'b1;
        score_value_d = value_q;
        level_score_d = (score_sum_s > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum_s[15:0];
        carrying_d    = 1'b0;
        move_speed_d  = BASE_SPEED;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; start_level clears the same state as reset.
  always_ff @(posedge clk) begin
    if (reset || start_level) begin
      state_q       <= IDLE;
      move_speed_q  <= BASE_SPEED;
      carrying_q    <= 1'b0;
      carried_id_q  <= 4'd0;
      weight_q      <= 2'd0;
      value_q       <= 8'd0;
      loot_remove_q <= 1'b0;
      score_add_q   <= 1'b0;
      score_value_q <= 8'd0;
      level_score_q <= 16'd0;
      miss_count_q  <= 8'd0;
    end else begin
      state_q       <= state_d;
      move_speed_q  <= move_speed_d;
      carrying_q    <= carrying_d;
      carried_id_q  <= carried_id_d;
      weight_q      <= weight_d;
      value_q       <= value_d;
      loot_remove_q <= loot_remove_d;
      score_add_q   <= score_add_d;
      score_value_q <= score_value_d;
      level_score_q <= level_score_d;
      miss_count_q  <= miss_count_d;
    end
  end

  // Registered copy of claw_returned for edge detection. It keeps tracking
  // through start_level so that a return held across the pulse is not recounted.
  always_ff @(posedge clk) begin
    if (reset) begin
      ret_q <= 1'b0;
    end else begin
      ret_q <= claw_returned;
    end
  end

  assign move_speed  = move_speed_q;
  assign carrying    = carrying_q;
  assign carried_id  = carried_id_q;
  assign loot_remove = loot_remove_q;
  assign score_add   = score_add_q;
  assign score_value = score_value_q;
  assign level_score = level_score_q;
  assign miss_count  = miss_count_q;

endmodule
